// File: rtl/posit_pkg.sv
// Shared posit definitions used by the posit encoder and decoder: format widths,
// the decoder state encoding and the two special bit patterns.
package posit_pkg;

    localparam int N  = 32;
    localparam int ES = 3;
    localparam int KW = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SIGN     = 3'd1,
        REGIME   = 3'd2,
        EXP      = 3'd3,
        MANT     = 3'd4,
        COMPLETE = 3'd5
    } state_t;

    localparam logic [N-1:0] POSIT_ZERO = 32'h0000_0000;
    localparam logic [N-1:0] POSIT_NAR  = 32'h8000_0000;

endpackage

// File: rtl/posit_decoder.sv
// Serial 32-bit posit decoder. A captured word is scanned MSB first, one bit per
// clock, and split into sign, regime value k, exponent bits and an MSB-aligned
// fraction. Every word takes the same 33-edge path from start to done, so a word
// that runs out of bits inside the regime or exponent simply leaves the remaining
// fields at zero.
module posit_decoder
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  posit_in,
    output logic          sign_out,
    output logic [KW-1:0] k_out,
    output logic [ES-1:0] exp_out,
    output logic [N-1:0]  mantissa_out,
    output logic          is_zero,
    output logic          is_nar,
    output logic          busy,
    output logic          done
);

    state_t        state_q;
    logic [N-1:0]  shift_q;
    logic [4:0]    bitIdx_q;
    logic [4:0]    run_q;
    logic [1:0]    expIdx_q;
    logic [4:0]    mantIdx_q;
    logic          refBit_q;
    logic          special_q;
    logic          sign_q;
    logic [KW-1:0] k_q;
    logic [ES-1:0] exp_q;
    logic [N-1:0]  mant_q;
    logic          isZero_q;
    logic          isNar_q;
    logic          done_q;

    logic          curBit;
    logic          lastBit;
    logic          runMatch;
    logic [4:0]    runNext;
    logic [KW-1:0] kCalc;

    // The bit under the scan head is always the MSB of the left-shifting register;
    // bitIdx tracks which original bit position that is, so bit 0 can end the scan.
    assign curBit   = shift_q[N-1];
    assign lastBit  = (bitIdx_q == 5'd0);
    assign runMatch = (curBit == refBit_q);
    // The run length including the current bit lets k be formed in the same cycle
    // the run ends, whether it ends on a terminator or on bit 0.
    assign runNext  = run_q + {4'd0, runMatch};
    assign kCalc    = refBit_q ? ({1'b0, runNext} - 6'd1) : (6'd0 - {1'b0, runNext});

    // Decode FSM: captures the word, walks it field by field and pulses done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitIdx_q  <= '0;
            run_q     <= '0;
            expIdx_q  <= '0;
            mantIdx_q <= '0;
            refBit_q  <= 1'b0;
            special_q <= 1'b0;
            sign_q    <= 1'b0;
            k_q       <= '0;
            exp_q     <= '0;
            mant_q    <= '0;
            isZero_q  <= 1'b0;
            isNar_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q   <= posit_in;
                        bitIdx_q  <= 5'd31;
                        run_q     <= '0;
                        expIdx_q  <= '0;
                        mantIdx_q <= '0;
                        sign_q    <= 1'b0;
                        k_q       <= '0;
                        exp_q     <= '0;
                        mant_q    <= '0;
                        special_q <= (posit_in[N-2:0] == '0);
                        isZero_q  <= (posit_in == POSIT_ZERO);
                        isNar_q   <= (posit_in == POSIT_NAR);
                        state_q   <= SIGN;
                    end
                end
                SIGN: begin
                    sign_q   <= curBit;
                    refBit_q <= shift_q[N-2];
                    run_q    <= '0;
                    shift_q  <= shift_q << 1;
                    bitIdx_q <= bitIdx_q - 5'd1;
                    state_q  <= REGIME;
                end
                REGIME: begin
                    shift_q  <= shift_q << 1;
                    bitIdx_q <= bitIdx_q - 5'd1;
                    run_q    <= runNext;
                    if (!runMatch || lastBit) begin
                        if (!special_q) begin
                            k_q <= kCalc;
                        end
                        state_q <= lastBit ? COMPLETE : EXP;
                    end
                end
                EXP: begin
                    if (!special_q) begin
                        exp_q[2'd2 - expIdx_q] <= curBit;
                    end
                    shift_q  <= shift_q << 1;
                    bitIdx_q <= bitIdx_q - 5'd1;
                    expIdx_q <= expIdx_q + 2'd1;
                    if (lastBit) begin
                        state_q <= COMPLETE;
                    end else if (expIdx_q == 2'd2) begin
                        state_q <= MANT;
                    end
                end
                MANT: begin
                    if (!special_q) begin
                        mant_q[5'd31 - mantIdx_q] <= curBit;
                    end
                    shift_q   <= shift_q << 1;
                    bitIdx_q  <= bitIdx_q - 5'd1;
                    mantIdx_q <= mantIdx_q + 5'd1;
                    if (lastBit) begin
                        state_q <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sign_out     = sign_q;
    assign k_out        = k_q;
    assign exp_out      = exp_q;
    assign mantissa_out = mant_q;
    assign is_zero      = isZero_q;
    assign is_nar       = isNar_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_posit_decoder.sv
// Directed bench for the serial posit decoder: reset state, field extraction,
// truncated words, handshake corner cases and an encode/decode round trip.
module tb_posit_decoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] posit_in;
    logic        sign_out;
    logic [5:0]  k_out;
    logic [2:0]  exp_out;
    logic [31:0] mantissa_out;
    logic        is_zero;
    logic        is_nar;
    logic        busy;
    logic        done;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [31:0] w;
        logic        s;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] m;
        logic        z;
        logic        n;
    } vec_t;

    posit_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .posit_in     (posit_in),
        .sign_out     (sign_out),
        .k_out        (k_out),
        .exp_out      (exp_out),
        .mantissa_out (mantissa_out),
        .is_zero      (is_zero),
        .is_nar       (is_nar),
        .busy         (busy),
        .done         (done)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one start and count rising edges after the accepting edge until done.
    task automatic runDecode(input logic [31:0] w, output int edges);
        @(negedge clk);
        start    = 1'b1;
        posit_in = w;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Reference encoder: builds a word from fields and reports which exponent
    // and fraction bits actually fit after the regime.
    function automatic logic [31:0] encode(input logic s, input int k, input logic [2:0] e,
                                           input logic [31:0] m,
                                           output logic [2:0] eFit, output logic [31:0] mFit);
        logic [31:0] w;
        int          pos;
        int          len;
        logic        rb;
        w    = '0;
        eFit = '0;
        mFit = '0;
        w[31] = s;
        pos  = 30;
        rb   = (k >= 0);
        len  = (k >= 0) ? k + 1 : -k;
        for (int i = 0; i < len; i++) begin
            if (pos >= 0) begin
                w[pos] = rb;
                pos--;
            end
        end
        if (pos >= 0) begin
            w[pos] = ~rb;
            pos--;
        end
        for (int i = 2; i >= 0; i--) begin
            if (pos >= 0) begin
                w[pos]  = e[i];
                eFit[i] = e[i];
                pos--;
            end
        end
        for (int j = 31; j >= 0; j--) begin
            if (pos >= 0) begin
                w[pos]  = m[j];
                mFit[j] = m[j];
                pos--;
            end
        end
        return w;
    endfunction

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b0;
        posit_in = '0;
        repeat (3) @(posedge clk);
        #1;
        assertCount++;
        if ({sign_out, k_out, exp_out, mantissa_out, is_zero, is_nar, busy, done} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got sign=%b k=%h exp=%b mant=%h z=%b n=%b busy=%b done=%b, want all 0",
                     sign_out, k_out, exp_out, mantissa_out, is_zero, is_nar, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_vectors();
        vec_t vecs[9];
        int   edges;
        vecs[0] = '{32'h0000_0000, 1'b0, 6'h00, 3'b000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h8000_0000, 1'b1, 6'h00, 3'b000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h4A80_0000, 1'b0, 6'h00, 3'b010, 32'hA000_0000, 1'b0, 1'b0};
        vecs[3] = '{32'h8800_0000, 1'b1, 6'h3D, 3'b000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 1'b0, 6'h1E, 3'b000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'h7FFF_FFFD, 1'b0, 6'h1C, 3'b100, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h4000_0001, 1'b0, 6'h00, 3'b000, 32'h0000_0040, 1'b0, 1'b0};
        vecs[7] = '{32'h3FFF_FFFF, 1'b0, 6'h3F, 3'b111, 32'hFFFF_FFC0, 1'b0, 1'b0};
        vecs[8] = '{32'hE000_0000, 1'b1, 6'h01, 3'b000, 32'h0000_0000, 1'b0, 1'b0};
        foreach (vecs[i]) begin
            runDecode(vecs[i].w, edges);
            assertCount++;
            if (edges !== 33) begin
                failCount++;
                $display("[TB] FAIL latency[%h]: done after %0d edges, want 33", vecs[i].w, edges);
            end
            assertCount++;
            if ({sign_out, k_out, exp_out, mantissa_out, is_zero, is_nar} !==
                {vecs[i].s, vecs[i].k, vecs[i].e, vecs[i].m, vecs[i].z, vecs[i].n}) begin
                failCount++;
                $display("[TB] FAIL fields[%h]: got s=%b k=%h e=%b m=%h z=%b n=%b, want s=%b k=%h e=%b m=%h z=%b n=%b",
                         vecs[i].w, sign_out, k_out, exp_out, mantissa_out, is_zero, is_nar,
                         vecs[i].s, vecs[i].k, vecs[i].e, vecs[i].m, vecs[i].z, vecs[i].n);
            end
        end
    endtask

    task automatic test_done_pulse();
        int edges;
        runDecode(32'h4A80_0000, edges);
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL busy_in_done: busy=%b, want 0", busy);
        end
        @(posedge clk);
        #1;
        assertCount++;
        if (done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL done_width: done=%b one cycle later, want 0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        assertCount++;
        if (exp_out !== 3'b010 || mantissa_out !== 32'hA000_0000) begin
            failCount++;
            $display("[TB] FAIL hold_outputs: exp=%b mant=%h, want 010 A0000000", exp_out, mantissa_out);
        end
    endtask

    task automatic test_start_while_busy();
        int edges;
        @(negedge clk);
        start    = 1'b1;
        posit_in = 32'h4A80_0000;
        @(posedge clk);
        #1;
        posit_in = 32'h8800_0000;
        edges = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        assertCount++;
        if (edges !== 33) begin
            failCount++;
            $display("[TB] FAIL busy_start_latency: done after %0d edges, want 33", edges);
        end
        assertCount++;
        if (sign_out !== 1'b0 || k_out !== 6'h00 || exp_out !== 3'b010) begin
            failCount++;
            $display("[TB] FAIL busy_start_fields: s=%b k=%h e=%b, want 0 00 010", sign_out, k_out, exp_out);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        runDecode(32'h8800_0000, edges);
        assertCount++;
        if (k_out !== 6'h3D || sign_out !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_first: s=%b k=%h, want 1 3d", sign_out, k_out);
        end
        runDecode(32'h4A80_0000, edges);
        assertCount++;
        if (edges !== 33) begin
            failCount++;
            $display("[TB] FAIL b2b_latency: done after %0d edges, want 33", edges);
        end
        assertCount++;
        if (sign_out !== 1'b0 || k_out !== 6'h00 || exp_out !== 3'b010 || mantissa_out !== 32'hA000_0000) begin
            failCount++;
            $display("[TB] FAIL b2b_second: s=%b k=%h e=%b m=%h, want 0 00 010 a0000000",
                     sign_out, k_out, exp_out, mantissa_out);
        end
    endtask

    task automatic test_reset_mid_decode();
        int edges;
        runDecode(32'hE000_0000, edges);
        @(negedge clk);
        start    = 1'b1;
        posit_in = 32'h3FFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        assertCount++;
        if ({sign_out, k_out, exp_out, mantissa_out, is_zero, is_nar, busy, done} !== '0) begin
            failCount++;
            $display("[TB] FAIL mid_reset: s=%b k=%h e=%b m=%h z=%b n=%b busy=%b done=%b, want all 0",
                     sign_out, k_out, exp_out, mantissa_out, is_zero, is_nar, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        runDecode(32'h3FFF_FFFF, edges);
        assertCount++;
        if (edges !== 33 || k_out !== 6'h3F || exp_out !== 3'b111 || mantissa_out !== 32'hFFFF_FFC0) begin
            failCount++;
            $display("[TB] FAIL after_reset: edges=%0d k=%h e=%b m=%h, want 33 3f 111 ffffffc0",
                     edges, k_out, exp_out, mantissa_out);
        end
    endtask

    task automatic test_round_trip();
        int          edges;
        int          k;
        logic        s;
        logic [2:0]  e;
        logic [31:0] m;
        logic [2:0]  eFit;
        logic [31:0] mFit;
        logic [31:0] w;
        logic [5:0]  kExp;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(1, 0));
            k = (i == 0) ? 30 : (i == 1) ? -30 : int'($urandom_range(60, 0)) - 30;
            e = 3'($urandom_range(7, 0));
            m = $urandom;
            w = encode(s, k, e, m, eFit, mFit);
            kExp = k[5:0];
            runDecode(w, edges);
            assertCount++;
            if (edges !== 33 || sign_out !== s || k_out !== kExp || exp_out !== eFit || mantissa_out !== mFit) begin
                failCount++;
                $display("[TB] FAIL round_trip[%h]: edges=%0d s=%b k=%h e=%b m=%h, want 33 s=%b k=%h e=%b m=%h",
                         w, edges, sign_out, k_out, exp_out, mantissa_out, s, kExp, eFit, mFit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_done_pulse();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_decode();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
